servant_wb_loader: RTL and testbench



---
 rtl/servant_wb_loader_pkg.sv | 28 ++
 rtl/servant_uart_rx.sv | 96 +++++++++
 rtl/servant_wb_loader.sv | 197 +++++++++++++++++++
 tb/tb_servant_wb_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_wb_loader_pkg.sv
// Shared types and constants for the UART program loader.
package servant_wb_loader_pkg;

  // Image parser states.
  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
    StDone
  } parse_state_e;

  // UART receiver states.
  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // Frame header byte that starts an image.
  localparam logic [7:0] Header = 8'hA5;

  // Full-word byte enables for every write.
  localparam logic [3:0] WbSel = 4'hf;

endpackage

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver: start-bit glitch rejection, centre sampling, frame error pulse.
module servant_uart_rx
  import servant_wb_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state, bit timer and shift register.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; valid/frame-error pulse on the stop-bit sample cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    o_valid     = 1'b0;
    o_frame_err = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid start bit: a glitch, not a start.
          state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RxStop;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = RxIdle;
          if (rx_sync_q) o_valid     = 1'b1;
          else           o_frame_err = 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign o_data = shift_q;

endmodule

// File: rtl/servant_wb_loader.sv
// Loads a framed program image from UART into memory over Wishbone, holding the CPU in reset.
module servant_wb_loader
  import servant_wb_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned memsize      = 8192
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_rx,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  output logic        o_cpu_rst,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned MaxWords = memsize / 4;
  localparam logic [31:0] AdrMask  = 32'(memsize - 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;

  servant_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .i_rx        (i_rx),
    .o_data      (rx_data),
    .o_valid     (rx_valid),
    .o_frame_err (rx_frame_err)
  );

  logic [7:0]   hold_data_q;
  logic         hold_full_q;
  logic         consume;
  logic         overrun;
  logic         len_err;
  logic         err_q;

  parse_state_e state_q, state_d;
  logic [7:0]   len_lo_q, len_lo_d;
  logic [15:0]  count_q, count_d;
  logic [15:0]  idx_q, idx_d;
  logic [15:0]  idx_next;
  logic [15:0]  n_words;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [31:0]  adr_q, adr_d;
  logic [31:0]  dat_q, dat_d;
  logic         stb_q, stb_d;
  logic         cpu_rst_q, cpu_rst_d;
  logic         done_q, done_d;

  // A pending byte waits while a bus write is in flight.
  assign consume  = hold_full_q && (state_q != StWrite);
  assign overrun  = rx_valid && hold_full_q && !consume;
  assign n_words  = {hold_data_q, len_lo_q};
  assign idx_next = idx_q + 16'd1;

  // One-byte holding register between receiver and parser.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
    end else if (rx_valid && !overrun) begin
      hold_data_q <= rx_data;
      hold_full_q <= 1'b1;
    end else if (consume) begin
      hold_full_q <= 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) err_q <= 1'b0;
    else        err_q <= err_q | rx_frame_err | overrun | len_err;
  end

  // Parser and bus registers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q    <= StIdle;
      len_lo_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      stb_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      stb_q      <= stb_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
    end
  end

  // Parser next-state: header, 16-bit word count, little-endian words, one write per word.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    stb_d      = stb_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    len_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (consume && hold_data_q == Header) state_d = StLen0;
      end
      StLen0: begin
        if (consume) begin
          len_lo_d = hold_data_q;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (consume) begin
          count_d = n_words;
          if (32'(n_words) > MaxWords) begin
            len_err = 1'b1;
            state_d = StIdle;
          end else if (n_words == 16'd0) begin
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
            state_d   = StDone;
          end else begin
            idx_d      = '0;
            byte_cnt_d = '0;
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (consume) begin
          dat_d      = {hold_data_q, dat_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            adr_d   = 32'({idx_q, 2'b00}) & AdrMask;
            stb_d   = 1'b1;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (stb_q && i_wb_ack) begin
          stb_d = 1'b0;
          idx_d = idx_next;
          if (idx_next == count_q) begin
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
            state_d   = StDone;
          end else begin
            byte_cnt_d = '0;
            state_d    = StData;
          end
        end
      end
      StDone: begin
        // A new header restarts loading and puts the CPU back in reset.
        if (consume && hold_data_q == Header) begin
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          state_d   = StLen0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = stb_q;
  assign o_wb_sel  = stb_q ? WbSel : 4'h0;
  assign o_cpu_rst = cpu_rst_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_servant_wb_loader.sv
// Directed bench for servant_wb_loader: UART byte driver, Wishbone responder, immediate checks.
module tb_servant_wb_loader;

  localparam int unsigned CPB = 8;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        i_rx = 1'b1;
  logic        i_wb_ack = 1'b0;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_stb, o_cpu_rst, o_done, o_err;

  servant_wb_loader #(
    .CLKS_PER_BIT(CPB),
    .memsize     (8192)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .i_rx     (i_rx),
    .o_wb_adr (o_wb_adr),
    .o_wb_dat (o_wb_dat),
    .o_wb_sel (o_wb_sel),
    .o_wb_we  (o_wb_we),
    .o_wb_stb (o_wb_stb),
    .i_wb_ack (i_wb_ack),
    .o_cpu_rst(o_cpu_rst),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  always #5 wb_clk = ~wb_clk;

  int errors = 0;
  int checks = 0;

  // Responder state and write log.
  int          ack_delay = 0;
  int          nwr = 0;
  int          viol = 0;
  logic [31:0] wr_adr[8];
  logic [31:0] wr_dat[8];
  logic [3:0]  wr_sel[8];
  int          wr_cyc[8];
  logic        done_at_ack = 1'b0;
  logic        done_after = 1'b0;
  logic        rst_after = 1'b1;

  // Wishbone responder: acks after ack_delay extra stb cycles, logs writes, watches stability.
  initial begin
    int          cnt;
    logic        ack_prev, stb_prev;
    logic [31:0] adr_prev, dat_prev;
    cnt = 0;
    ack_prev = 1'b0;
    stb_prev = 1'b0;
    adr_prev = '0;
    dat_prev = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      if (ack_prev) begin
        done_after = o_done;
        rst_after  = o_cpu_rst;
      end
      ack_prev = 1'b0;
      if (o_wb_stb && stb_prev && (o_wb_adr !== adr_prev || o_wb_dat !== dat_prev)) viol++;
      stb_prev = o_wb_stb;
      adr_prev = o_wb_adr;
      dat_prev = o_wb_dat;
      if (o_wb_stb) begin
        if (cnt == ack_delay) begin
          i_wb_ack = 1'b1;
          if (nwr < 8) begin
            wr_adr[nwr] = o_wb_adr;
            wr_dat[nwr] = o_wb_dat;
            wr_sel[nwr] = o_wb_sel;
            wr_cyc[nwr] = cnt + 1;
          end
          nwr++;
          done_at_ack = o_done;
          ack_prev = 1'b1;
          cnt = 0;
        end else begin
          i_wb_ack = 1'b0;
          cnt++;
        end
      end else begin
        i_wb_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    i_rx = stop;
    tick(CPB);
    i_rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (nwr < n && t < 2000) begin
      tick(1);
      t++;
    end
    tick(4);
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    tick(3);
    wb_rst = 1'b0;
    tick(2);
    nwr = 0;
    viol = 0;
    done_after = 1'b0;
    rst_after = 1'b1;
    done_at_ack = 1'b0;
  endtask

  logic [7:0] img[$];

  initial begin
    img = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tick(3);

    // Reset values.
    chk("rst_stb", 32'(o_wb_stb), 32'd0);
    chk("rst_we", 32'(o_wb_we), 32'd0);
    chk("rst_adr", o_wb_adr, 32'd0);
    chk("rst_dat", o_wb_dat, 32'd0);
    chk("rst_sel", 32'(o_wb_sel), 32'd0);
    chk("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);

    // Two-word image, single-cycle ack.
    do_reset();
    ack_delay = 0;
    send_seq(img);
    wait_writes(2);
    chk("t1_nwr", 32'(nwr), 32'd2);
    chk("t1_adr0", wr_adr[0], 32'h0000_0000);
    chk("t1_dat0", wr_dat[0], 32'h1234_5678);
    chk("t1_adr1", wr_adr[1], 32'h0000_0004);
    chk("t1_dat1", wr_dat[1], 32'hDEAD_BEEF);
    chk("t1_sel", 32'(wr_sel[1]), 32'hf);
    chk("t1_cyc", 32'(wr_cyc[0]), 32'd1);
    chk("t1_done_at_ack", 32'(done_at_ack), 32'd0);
    chk("t1_done_after", 32'(done_after), 32'd1);
    chk("t1_cpu_rst_after", 32'(rst_after), 32'd0);
    chk("t1_err", 32'(o_err), 32'd0);
    chk("t1_stb_idle", 32'(o_wb_stb), 32'd0);

    // Same image, ack delayed five cycles.
    do_reset();
    ack_delay = 5;
    send_seq(img);
    wait_writes(2);
    chk("t2_nwr", 32'(nwr), 32'd2);
    chk("t2_cyc0", 32'(wr_cyc[0]), 32'd6);
    chk("t2_cyc1", 32'(wr_cyc[1]), 32'd6);
    chk("t2_dat0", wr_dat[0], 32'h1234_5678);
    chk("t2_dat1", wr_dat[1], 32'hDEAD_BEEF);
    chk("t2_adr1", wr_adr[1], 32'h0000_0004);
    chk("t2_stable", 32'(viol), 32'd0);
    chk("t2_done", 32'(o_done), 32'd1);

    // Leading garbage, then an empty image.
    do_reset();
    ack_delay = 0;
    send_seq('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00});
    chk("t3_done_early", 32'(o_done), 32'd0);
    chk("t3_cpu_rst_early", 32'(o_cpu_rst), 32'd1);
    send_byte(8'h00, 1'b1);
    chk("t3_done", 32'(o_done), 32'd1);
    chk("t3_cpu_rst", 32'(o_cpu_rst), 32'd0);
    chk("t3_err", 32'(o_err), 32'd0);
    chk("t3_nwr", 32'(nwr), 32'd0);

    // Header byte with a bad stop bit, then a valid one-word image.
    do_reset();
    send_byte(8'hA5, 1'b0);
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_cpu_rst_mid", 32'(o_cpu_rst), 32'd1);
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    wait_writes(1);
    chk("t4_nwr", 32'(nwr), 32'd1);
    chk("t4_adr0", wr_adr[0], 32'h0000_0000);
    chk("t4_dat0", wr_dat[0], 32'h4433_2211);
    chk("t4_cpu_rst", 32'(o_cpu_rst), 32'd0);
    chk("t4_err_sticky", 32'(o_err), 32'd1);

    // Oversized length: 0x0801 words exceeds 2048.
    do_reset();
    send_seq('{8'hA5, 8'h01, 8'h08});
    tick(4);
    chk("t5_err", 32'(o_err), 32'd1);
    chk("t5_nwr", 32'(nwr), 32'd0);
    chk("t5_cpu_rst", 32'(o_cpu_rst), 32'd1);
    chk("t5_done", 32'(o_done), 32'd0);

    // Reset in the middle of a write, then a full reload.
    do_reset();
    ack_delay = 1000;
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    begin
      int t;
      t = 0;
      while (!o_wb_stb && t < 500) begin
        tick(1);
        t++;
      end
    end
    chk("t6_stb_before", 32'(o_wb_stb), 32'd1);
    #2;
    wb_rst = 1'b1;
    #1;
    chk("t6_stb_async", 32'(o_wb_stb), 32'd0);
    chk("t6_cpu_rst", 32'(o_cpu_rst), 32'd1);
    tick(3);
    wb_rst = 1'b0;
    ack_delay = 0;
    tick(2);
    nwr = 0;
    send_seq('{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    wait_writes(1);
    chk("t6_nwr", 32'(nwr), 32'd1);
    chk("t6_adr0", wr_adr[0], 32'h0000_0000);
    chk("t6_dat0", wr_dat[0], 32'hDDCC_BBAA);
    chk("t6_done", 32'(o_done), 32'd1);
    chk("t6_cpu_rst_end", 32'(o_cpu_rst), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
